// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: decodes on entry, holds results in a main register
// backed by a one-entry skid register so in_ready can be registered without losing throughput.
module decode_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ZERO_RD_WE = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_inst,
    input  logic [XLEN-1:0] i_in_pc,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_imm,
    output logic [3:0]      o_alu_ctrl,
    output logic            o_rd_we,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_pc
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Payload layout: {rs1, rs2, rd, alu_ctrl, rd_we, illegal, imm, pc}
    localparam int unsigned PW = 2 * XLEN + 21;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [3:0]      w_alu_raw;
    logic [3:0]      w_alu;
    logic            w_we_raw;
    logic            w_illegal;
    logic            w_rd_we;
    logic [PW-1:0]   w_in_data;

    assign w_opcode = i_in_inst[6:0];
    assign w_funct3 = i_in_inst[14:12];
    assign w_funct7 = i_in_inst[31:25];
    assign w_rs1    = i_in_inst[19:15];
    assign w_rs2    = i_in_inst[24:20];
    assign w_rd     = i_in_inst[11:7];

    always_comb begin
        w_imm32   = '0;
        w_alu_raw = ALU_ADD;
        w_we_raw  = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_imm32  = {i_in_inst[31:12], 12'b0};
                w_we_raw = 1'b1;
            end
            OPC_JAL: begin
                w_imm32  = {{11{i_in_inst[31]}}, i_in_inst[31], i_in_inst[19:12],
                            i_in_inst[20], i_in_inst[30:21], 1'b0};
                w_we_raw = 1'b1;
            end
            OPC_JALR: begin
                w_imm32   = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
                w_we_raw  = 1'b1;
                w_illegal = (w_funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_imm32   = {{19{i_in_inst[31]}}, i_in_inst[31], i_in_inst[7],
                             i_in_inst[30:25], i_in_inst[11:8], 1'b0};
                w_alu_raw = ALU_SUB;
            end
            OPC_LOAD: begin
                w_imm32  = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
                w_we_raw = 1'b1;
            end
            OPC_STORE: begin
                w_imm32 = {{20{i_in_inst[31]}}, i_in_inst[31:25], i_in_inst[11:7]};
            end
            OPC_OP_IMM: begin
                w_imm32   = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
                w_we_raw  = 1'b1;
                w_alu_raw = {1'b0, w_funct3};
                if (w_funct3 == 3'b001) begin
                    w_illegal = (w_funct7 != F7_BASE);
                end else if (w_funct3 == 3'b101) begin
                    // Only shifts borrow inst[30] as the arithmetic/logical select
                    w_alu_raw = {i_in_inst[30], 3'b101};
                    w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
                end
            end
            OPC_OP: begin
                w_we_raw  = 1'b1;
                w_alu_raw = {i_in_inst[30], w_funct3};
                if (w_funct7 == F7_ALT) begin
                    w_illegal = (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
                end else if (w_funct7 != F7_BASE) begin
                    w_illegal = 1'b1;
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_imm       = {XLEN{w_imm32[31]}};
        w_imm[31:0] = w_imm32;
    end

    assign w_alu   = w_illegal ? ALU_ADD : w_alu_raw;
    assign w_rd_we = w_we_raw && !w_illegal && !((ZERO_RD_WE != 0) && (w_rd == 5'd0));

    assign w_in_data = {w_rs1, w_rs2, w_rd, w_alu, w_rd_we, w_illegal, w_imm, i_in_pc};

    logic          r_main_valid;
    logic          r_skid_valid;
    logic          r_in_ready;
    logic [PW-1:0] r_main_data;
    logic [PW-1:0] r_skid_data;

    logic w_in_xfer;
    logic w_out_xfer;

    assign w_in_xfer  = i_in_valid && r_in_ready;
    assign w_out_xfer = r_main_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_main_valid || w_out_xfer) begin
            // in_ready is low whenever skid holds data, so at most one source applies
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_in_xfer) begin
                r_main_data  <= w_in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid_data  <= w_in_data;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_main_valid;
    assign {o_rs1, o_rs2, o_rd, o_alu_ctrl, o_rd_we, o_illegal, o_imm, o_pc} = r_main_data;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; a 32-bit and a 64-bit instance share stimulus.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [63:0] in_pc64;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu_ctrl;
    logic        rd_we, illegal;
    logic [31:0] pc;

    logic        in_ready64;
    logic        out_valid64;
    logic [4:0]  rs1_64, rs2_64, rd_64;
    logic [63:0] imm64;
    logic [3:0]  alu_ctrl64;
    logic        rd_we64, illegal64;
    logic [63:0] pc64;

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        we;
        logic        ill;
        logic        chk_imm;
    } vec_t;

    vec_t vecs[14];

    decode_stage #(.XLEN(32), .ZERO_RD_WE(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .i_in_inst(in_inst), .i_in_pc(in_pc),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd), .o_imm(imm), .o_alu_ctrl(alu_ctrl),
        .o_rd_we(rd_we), .o_illegal(illegal), .o_pc(pc)
    );

    decode_stage #(.XLEN(64), .ZERO_RD_WE(1)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(in_ready64), .i_in_inst(in_inst), .i_in_pc(in_pc64),
        .o_out_valid(out_valid64), .i_out_ready(out_ready),
        .o_rs1(rs1_64), .o_rs2(rs2_64), .o_rd(rd_64), .o_imm(imm64), .o_alu_ctrl(alu_ctrl64),
        .o_rd_we(rd_we64), .o_illegal(illegal64), .o_pc(pc64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves A (pc 0xA0) in main and B (pc 0xB0) in skid with out_ready low.
    task automatic fill_two();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h002081B3;
        in_pc     = 32'hA0;
        tick();
        in_inst = 32'h40208133;
        in_pc   = 32'hB0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
        in_pc = '0; in_pc64 = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if ({rs1, rs2, rd, imm, alu_ctrl, rd_we, illegal, pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rs1=%0d rs2=%0d rd=%0d imm=%h alu=%h we=%b ill=%b pc=%h want all 0",
                     rs1, rs2, rd, imm, alu_ctrl, rd_we, illegal, pc);
        end
    endtask

    task automatic test_decode();
        logic [31:0] exp_pc;
        vecs[0]  = '{32'h002081B3, 5'd1,  5'd2,  5'd3,  32'h0,        4'h0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h40208133, 5'd1,  5'd2,  5'd2,  32'h0,        4'h8, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'hFFF00093, 5'd0,  5'd31, 5'd1,  32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'hFE000EE3, 5'd0,  5'd0,  5'd29, 32'hFFFFFFFC, 4'h8, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h800002B7, 5'd0,  5'd0,  5'd5,  32'h80000000, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{32'h0020A423, 5'd1,  5'd2,  5'd8,  32'h8,        4'h0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{32'h001000EF, 5'd0,  5'd1,  5'd1,  32'h800,      4'h0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h407352B3, 5'd6,  5'd7,  5'd5,  32'h0,        4'hD, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{32'h40335293, 5'd6,  5'd3,  5'd5,  32'h403,      4'hD, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 32'h0,        4'h0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h4020C1B3, 5'd1,  5'd2,  5'd3,  32'h0,        4'h0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{32'h00100013, 5'd0,  5'd1,  5'd0,  32'h1,        4'h0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{32'h000090E7, 5'd1,  5'd0,  5'd1,  32'h0,        4'h0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{32'h40331293, 5'd6,  5'd3,  5'd5,  32'h403,      4'h0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            exp_pc   = 32'h1000 + 32'(i * 4);
            in_pc    = exp_pc;
            tick();
            n_cmp++;
            if ({out_valid, rs1, rs2, rd, alu_ctrl, rd_we, illegal, pc} !==
                {1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].alu, vecs[i].we,
                 vecs[i].ill, exp_pc}) begin
                n_fail++;
                $display("FAIL decode_%0d inst=%h: got v=%b rs1=%0d rs2=%0d rd=%0d alu=%h we=%b ill=%b pc=%h want v=1 rs1=%0d rs2=%0d rd=%0d alu=%h we=%b ill=%b pc=%h",
                         i, vecs[i].inst, out_valid, rs1, rs2, rd, alu_ctrl, rd_we, illegal, pc,
                         vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].alu, vecs[i].we,
                         vecs[i].ill, exp_pc);
            end
            if (vecs[i].chk_imm) begin
                n_cmp++;
                if (imm !== vecs[i].imm) begin
                    n_fail++;
                    $display("FAIL decode_imm_%0d inst=%h: got %h want %h",
                             i, vecs[i].inst, imm, vecs[i].imm);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL decode_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        fill_two();
        in_inst = 32'hFFF00093;
        in_pc   = 32'hC0;
        n_cmp++;
        if ({out_valid, in_ready, pc} !== {1'b1, 1'b0, 32'hA0}) begin
            n_fail++;
            $display("FAIL bp_skid_full: got v=%b rdy=%b pc=%h want v=1 rdy=0 pc=a0",
                     out_valid, in_ready, pc);
        end
        tick();
        n_cmp++;
        if ({out_valid, in_ready, pc, rd} !== {1'b1, 1'b0, 32'hA0, 5'd3}) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b rdy=%b pc=%h rd=%0d want v=1 rdy=0 pc=a0 rd=3",
                     out_valid, in_ready, pc, rd);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, in_ready, pc, rd} !== {1'b1, 1'b1, 32'hB0, 5'd2}) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b rdy=%b pc=%h rd=%0d want v=1 rdy=1 pc=b0 rd=2",
                     out_valid, in_ready, pc, rd);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, pc, rd, imm} !== {1'b1, 32'hC0, 5'd1, 32'hFFFFFFFF}) begin
            n_fail++;
            $display("FAIL bp_third: got v=%b pc=%h rd=%0d imm=%h want v=1 pc=c0 rd=1 imm=ffffffff",
                     out_valid, pc, rd, imm);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_duplicate: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        fill_two();
        in_inst = 32'h00100013;
        in_pc   = 32'hC4;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_empty: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_dropped: out_valid got %b pc=%h want 0", out_valid, pc);
        end
        in_valid = 1'b1;
        in_inst  = 32'h0020A423;
        in_pc    = 32'hD0;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, pc, rd} !== {1'b1, 32'hD0, 5'd8}) begin
            n_fail++;
            $display("FAIL flush_resume: got v=%b pc=%h rd=%0d want v=1 pc=d0 rd=8",
                     out_valid, pc, rd);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        fill_two();
        in_inst = 32'hFFF00093;
        in_pc   = 32'hE0;
        rst     = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        n_cmp++;
        if ({rs1, rs2, rd, imm, alu_ctrl, rd_we, illegal, pc, imm64, pc64} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_data: got rd=%0d imm=%h pc=%h imm64=%h pc64=%h want all 0",
                     rd, imm, pc, imm64, pc64);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_stays_empty: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_xlen64();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF00093;
        in_pc     = 32'h2000;
        in_pc64   = 64'hDEAD_BEEF_0000_2000;
        tick();
        in_inst = 32'h800002B7;
        in_pc64 = 64'h8000_0001_0000_2004;
        n_cmp++;
        if ({out_valid64, imm64, pc64, rd_64} !==
            {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0000_2000, 5'd1}) begin
            n_fail++;
            $display("FAIL x64_addi: got v=%b imm=%h pc=%h rd=%0d want v=1 imm=ffffffffffffffff pc=deadbeef00002000 rd=1",
                     out_valid64, imm64, pc64, rd_64);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({imm64, pc64, rd_64, rd_we64, illegal64, alu_ctrl64} !==
            {64'hFFFF_FFFF_8000_0000, 64'h8000_0001_0000_2004, 5'd5, 1'b1, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL x64_lui: got imm=%h pc=%h rd=%0d we=%b ill=%b alu=%h want imm=ffffffff80000000 pc=8000000100002004 rd=5 we=1 ill=0 alu=0",
                     imm64, pc64, rd_64, rd_we64, illegal64, alu_ctrl64);
        end
        n_cmp++;
        if (imm !== 32'h8000_0000) begin
            n_fail++; $display("FAIL x32_lui_imm: got %h want 80000000", imm);
        end
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_xlen64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
